mult_unit: RTL and testbench

Iterative RV32M multiplier for the single-cycle core. It computes MUL, MULH, MULHSU and MULHU over several clock cycles and drives `multResult`, which feeds the ALU result select mux. While it is busy, the core stalls the PC.

---
 rtl/mult_unit_pkg.sv | 28 ++
 rtl/mult_unit_step.sv | 39 +++
 rtl/mult_unit.sv | 138 +++++++++++++
 tb/tb_mult_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mult_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
// Build option: MULT_RADIX4_EN selects the 2-bits-per-cycle datapath.
package mult_pkg;

  localparam int XLEN = 32;

`ifdef MULT_RADIX4_EN
  localparam int RADIX_BITS = 2;
`else
  localparam int RADIX_BITS = 1;
`endif

  localparam int MULT_STEPS = XLEN / RADIX_BITS;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mulOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } multState_t;

endpackage

// File: rtl/mult_unit_step.sv
// One combinational shift-add step of the multiplier.
// Build option: MULT_RADIX4_EN retires two multiplier bits per step.
module multStep
  import mult_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [DW-1:0]         acc,
  input  logic [DW-1:0]         mcand,
`ifdef MULT_RADIX4_EN
  input  logic [DW-1:0]         mcand3,
`endif
  input  logic [RADIX_BITS-1:0] mbits,
  output logic [DW-1:0]         accNext
);

  logic [DW-1:0] pp;

`ifdef MULT_RADIX4_EN
  // 3x comes in precomputed so the step stays a single adder
  always_comb begin
    pp = '0;
    unique case (mbits)
      2'b00: pp = '0;
      2'b01: pp = mcand;
      2'b10: pp = mcand << 1;
      2'b11: pp = mcand3;
      default: pp = '0;
    endcase
    accNext = acc + pp;
  end
`else
  always_comb begin
    pp = mbits[0] ? mcand : '0;
    accNext = acc + pp;
  end
`endif

endmodule

// File: rtl/mult_unit.sv
// Iterative RV32M multiplier: MUL, MULH, MULHSU, MULHU on magnitudes.
// Build option: MULT_RADIX4_EN halves the number of busy cycles.
module mult_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            start,
  input  logic [1:0]      mulOp,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] multResult
);

  import mult_pkg::*;

  localparam int DW     = 2 * XLEN;
  localparam int NSTEPS = XLEN / RADIX_BITS;
  localparam int CW     = $clog2(NSTEPS);

  multState_t      state;
  multState_t      stateNext;
  mulOp_t          opReg;
  logic            negFlag;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   accNext;
  logic [DW-1:0]   mcand;
  logic [DW-1:0]   mcandInit;
`ifdef MULT_RADIX4_EN
  logic [DW-1:0]   mcand3;
`endif
  logic [XLEN-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic            aNeg;
  logic            bNeg;
  logic [XLEN-1:0] magA;
  logic [XLEN-1:0] magB;
  logic [DW-1:0]   prod;
  logic            lastStep;

  // Only signed operands with bit 31 set are folded to magnitudes
  always_comb begin
    aNeg = 1'b0;
    bNeg = 1'b0;
    unique case (1'b1)
      (mulOp == OP_MULH): begin
        aNeg = srcA[XLEN-1];
        bNeg = srcB[XLEN-1];
      end
      (mulOp == OP_MULHSU): aNeg = srcA[XLEN-1];
      default: ;
    endcase
    magA = aNeg ? -srcA : srcA;
    magB = bNeg ? -srcB : srcB;
    mcandInit = {{(DW-XLEN){1'b0}}, magA};
  end

  assign lastStep = (cnt == CW'(NSTEPS - 1));
  assign prod     = negFlag ? -acc : acc;
  assign busy     = (state != IDLE);

  multStep #(
    .DW(DW)
  ) u_step (
    .acc     (acc),
    .mcand   (mcand),
`ifdef MULT_RADIX4_EN
    .mcand3  (mcand3),
`endif
    .mbits   (mplier[RADIX_BITS-1:0]),
    .accNext (accNext)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = BUSY;
      BUSY:    if (lastStep) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      opReg      <= OP_MUL;
      negFlag    <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
`ifdef MULT_RADIX4_EN
      mcand3     <= '0;
`endif
      mplier     <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      multResult <= '0;
    end else begin
      done <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (start) begin
            opReg   <= mulOp_t'(mulOp);
            negFlag <= aNeg ^ bNeg;
            acc     <= '0;
            mcand   <= mcandInit;
`ifdef MULT_RADIX4_EN
            mcand3  <= (mcandInit << 1) + mcandInit;
`endif
            mplier  <= magB;
            cnt     <= '0;
          end
        end
        BUSY: begin
          acc    <= accNext;
          mcand  <= mcand << RADIX_BITS;
`ifdef MULT_RADIX4_EN
          mcand3 <= mcand3 << RADIX_BITS;
`endif
          mplier <= mplier >> RADIX_BITS;
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          multResult <= (opReg == OP_MUL) ? prod[XLEN-1:0]
                                          : prod[DW-1:XLEN];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed RV32M corner cases,
// hold-start and mid-operation reset, then randomized operations.
module tb_mult_unit;

`ifdef MULT_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mulOp = 2'b00;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        busy;
  logic        done;
  logic [31:0] multResult;

  int checks = 0;
  int errors = 0;

  mult_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .start      (start),
    .mulOp      (mulOp),
    .srcA       (srcA),
    .srcB       (srcB),
    .busy       (busy),
    .done       (done),
    .multResult (multResult)
  );

  always #5 clk = ~clk;

  // Reference: full 64-bit product from sign/zero-extended operands
  function automatic logic [31:0] refModel(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done after the launch edge; returns edges taken
  task automatic waitDone(output int n, output bit busyOk);
    n = 0;
    busyOk = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic doOp(input string tag, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    int n;
    bit bok;
    logic [31:0] exp;
    exp = refModel(op, a, b);
    @(negedge clk);
    start = 1'b1; mulOp = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(n, bok);
    chk({tag, "_lat"}, 64'(n), 64'(LAT));
    chk({tag, "_busy"}, 64'(bok), 64'd1);
    chk({tag, "_res"}, 64'(multResult), 64'(exp));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 64'(done), 64'd0);
    chk({tag, "_hold"}, 64'(multResult), 64'(exp));
  endtask

  initial begin
    int n;
    bit bok;
    int pulses;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res", 64'(multResult), 64'd0);
    @(negedge clk);
    resetN = 1'b1;

    doOp("mul7x6", 2'd0, 32'd7, 32'd6);
    chk("mul7x6_val", 64'(multResult), 64'h2A);
    doOp("mul_ff", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    doOp("mulh_ff", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    doOp("mulhu_ff", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    doOp("mulhsu_ff", 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mulhsu_ff_val", 64'(multResult), 64'hFFFFFFFF);
    doOp("mulh_min", 2'd1, 32'h80000000, 32'h80000000);
    chk("mulh_min_val", 64'(multResult), 64'h40000000);
    doOp("mulhsu_min", 2'd2, 32'h80000000, 32'h80000000);
    chk("mulhsu_min_val", 64'(multResult), 64'hC0000000);

    // start held high, operands swapped mid-flight
    @(negedge clk);
    start = 1'b1; mulOp = 2'd0; srcA = 32'd1000; srcB = 32'd77;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    srcA = 32'd3; srcB = 32'd3;
    waitDone(n, bok);
    chk("hold_lat", 64'(n + 5), 64'(LAT));
    chk("hold_res1", 64'(multResult), 64'd77000);
    @(posedge clk); #1;
    chk("hold_relaunch", 64'(busy), 64'd1);
    start = 1'b0;
    waitDone(n, bok);
    chk("hold_lat2", 64'(n), 64'(LAT));
    chk("hold_res2", 64'(multResult), 64'd9);
    repeat (3) begin @(posedge clk); #1; end
    chk("hold_stay_idle", 64'(busy), 64'd0);

    // reset in the middle of an operation
    @(negedge clk);
    start = 1'b1; mulOp = 2'd0; srcA = 32'd11; srcB = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    resetN = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_res", 64'(multResult), 64'd0);
    @(negedge clk);
    resetN = 1'b1;
    pulses = 0;
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("abort_nodone", 64'(pulses), 64'd0);
    chk("abort_res_kept", 64'(multResult), 64'd0);
    doOp("after_rst", 2'd0, 32'd5, 32'd5);
    chk("after_rst_val", 64'(multResult), 64'd25);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 0) ra = {ra[31], 31'h0};
      if (i % 8 == 1) rb = 32'hFFFFFFFF;
      doOp($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
